// File: rtl/ahb_lite_master.sv
// AHB-Lite single-master initiator: command/response stream to pipelined SINGLE transfers.
// Optional AHB_MST_ERR_CANCEL_EN cancels the pipelined address phase on a two-cycle HRESP error.
module ahb_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [1:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
    // cmd_ready never depends on cmd_valid. rsp_valid is a one-cycle pulse with no backpressure.

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic                  ap_valid_q, ap_valid_d;
    logic [ADDR_WIDTH-1:0] ap_addr_q,  ap_addr_d;
    logic                  ap_write_q, ap_write_d;
    logic [1:0]            ap_size_q,  ap_size_d;
    logic [DATA_WIDTH-1:0] ap_wdata_q, ap_wdata_d;

    logic                  dp_valid_q, dp_valid_d;
    logic                  dp_write_q, dp_write_d;
    logic [DATA_WIDTH-1:0] dp_wdata_q, dp_wdata_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

    logic                  hold_ap;
    logic                  cmd_fire;
    logic                  ap_adv;
    logic                  dp_done;
    logic [1:0]            size_norm;

`ifdef AHB_MST_ERR_CANCEL_EN
    // cancel_q covers the second error cycle, after HREADY has already risen.
    logic cancel_q, cancel_d;
    logic dp_err_first;

    assign dp_err_first = dp_valid_q && HRESP && !HREADY;
    assign hold_ap      = dp_err_first || cancel_q;

    always_comb begin
        cancel_d = cancel_q;
        if (dp_err_first) begin
            cancel_d = 1'b1;
        end else if (HREADY) begin
            cancel_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cancel_q <= 1'b0;
        end else begin
            cancel_q <= cancel_d;
        end
    end
`else
    assign hold_ap = 1'b0;
`endif

    assign cmd_ready = (!ap_valid_q || (HREADY && !(dp_valid_q && HRESP))) && !hold_ap;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign ap_adv    = ap_valid_q && HREADY && !hold_ap;
    assign dp_done   = dp_valid_q && HREADY;
    assign size_norm = (cmd_size == 2'b11) ? 2'b00 : cmd_size;

    always_comb begin
        ap_valid_d  = ap_valid_q;
        ap_addr_d   = ap_addr_q;
        ap_write_d  = ap_write_q;
        ap_size_d   = ap_size_q;
        ap_wdata_d  = ap_wdata_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        dp_wdata_d  = dp_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        // Address stage empties or hands over, then refills from an accepted command.
        if (ap_adv || !ap_valid_q) begin
            ap_valid_d = cmd_fire;
            if (cmd_fire) begin
                ap_addr_d  = cmd_addr;
                ap_write_d = cmd_write;
                ap_size_d  = size_norm;
                ap_wdata_d = cmd_wdata;
            end
        end

        if (HREADY) begin
            dp_valid_d = ap_adv;
            if (ap_adv) begin
                dp_write_d = ap_write_q;
                dp_wdata_d = ap_wdata_q;
            end
        end

        if (dp_done) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = HRESP;
            rsp_rdata_d = dp_write_q ? '0 : HRDATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ap_valid_q  <= 1'b0;
            ap_addr_q   <= '0;
            ap_write_q  <= 1'b0;
            ap_size_q   <= 2'b00;
            ap_wdata_q  <= '0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_wdata_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ap_valid_q  <= ap_valid_d;
            ap_addr_q   <= ap_addr_d;
            ap_write_q  <= ap_write_d;
            ap_size_q   <= ap_size_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            dp_wdata_q  <= dp_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign HTRANS    = (ap_valid_q && !hold_ap) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = ap_addr_q;
    assign HWRITE    = ap_write_q;
    assign HSIZE     = {1'b0, ap_size_q};
    assign HBURST    = 3'b000;
    assign HWDATA    = dp_valid_q ? dp_wdata_q : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
